// File: rtl/free_list.sv
// free_list: block-index allocator built from a circular FIFO of free indices
// plus an in-use bitmap that flags bad or repeated frees.
module free_list #(
  parameter int ADDR_W = 8,
  parameter int NUM_BLOCKS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_req_i,
  output logic              alloc_gnt_o,
  output logic [ADDR_W-1:0] alloc_block_idx_o,
  input  logic              free_req_i,
  input  logic [ADDR_W-1:0] free_block_idx_i,
  output logic [ADDR_W:0]   free_count_o,
  output logic              init_done_o,
  output logic              err_double_free_o,
  output logic              err_bad_idx_o
);
  typedef enum logic {INIT, RUN} state_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_BLOCKS - 1);
  state_t state, state_nxt;
  logic [ADDR_W-1:0] fifo [NUM_BLOCKS];
  logic [ADDR_W-1:0] rd_ptr, wr_ptr;
  logic [2**ADDR_W-1:0] in_use;
  logic run, nonempty, idx_ok, free_ok;
  function automatic logic [ADDR_W-1:0] inc(input logic [ADDR_W-1:0] p);
    return p == LAST ? '0 : p + ADDR_W'(1);
  endfunction
  always_comb begin
    run = state == RUN;
    nonempty = free_count_o != '0;
    alloc_gnt_o = run && alloc_req_i && nonempty;
    alloc_block_idx_o = run && nonempty ? fifo[rd_ptr] : '0;
    idx_ok = {1'b0, free_block_idx_i} < (ADDR_W+1)'(NUM_BLOCKS);
    free_ok = run && free_req_i && idx_ok && in_use[free_block_idx_i];
    init_done_o = run;
    state_nxt = state == INIT && wr_ptr == LAST ? RUN : state;
  end
  always_ff @(posedge clk) state <= rst ? INIT : state_nxt;
  // During INIT wr_ptr doubles as the init counter and wraps to 0 on the last write.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      free_count_o <= '0;
      in_use <= '0;
      err_double_free_o <= 1'b0;
      err_bad_idx_o <= 1'b0;
    end else if (!run) begin
      wr_ptr <= inc(wr_ptr);
      free_count_o <= free_count_o + (ADDR_W+1)'(1);
    end else begin
      if (alloc_gnt_o) rd_ptr <= inc(rd_ptr);
      if (free_ok) wr_ptr <= inc(wr_ptr);
      free_count_o <= free_count_o + (ADDR_W+1)'(free_ok) - (ADDR_W+1)'(alloc_gnt_o);
      if (free_ok) in_use[free_block_idx_i] <= 1'b0;
      if (alloc_gnt_o) in_use[alloc_block_idx_o] <= 1'b1;
      if (free_req_i && !idx_ok) err_bad_idx_o <= 1'b1;
      if (free_req_i && idx_ok && !in_use[free_block_idx_i]) err_double_free_o <= 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (!rst && (!run || free_ok)) fifo[wr_ptr] <= run ? free_block_idx_i : wr_ptr;
endmodule

// File: tb/tb_free_list.sv
// tb_free_list: drives an 8-block and a 6-block free_list with shared stimulus and
// scores both against a queue-based model of the free pool.
module tb_free_list;
  typedef struct {
    bit chk;
    bit gnt;
    logic [2:0] idx;
    int cnt;
    bit done;
    bit db;
    bit bad;
  } st_t;
  logic clk = 0;
  logic rst, areq, freq;
  logic [2:0] fidx;
  logic [1:0] gnt, done, edb, ebad;
  logic [2:0] aidx [2];
  logic [3:0] cnt [2];
  int total = 0, bad = 0;
  int mq [2][$];
  int gq [2][$];
  st_t sq [2][$];
  bit inuse [2][8];
  int icnt [2];
  bit run [2], mdb [2], mbad [2];
  always #5 clk = ~clk;
  free_list #(.ADDR_W(3), .NUM_BLOCKS(8)) dut8 (
    .clk(clk), .rst(rst), .alloc_req_i(areq), .alloc_gnt_o(gnt[0]), .alloc_block_idx_o(aidx[0]),
    .free_req_i(freq), .free_block_idx_i(fidx), .free_count_o(cnt[0]), .init_done_o(done[0]),
    .err_double_free_o(edb[0]), .err_bad_idx_o(ebad[0]));
  free_list #(.ADDR_W(3), .NUM_BLOCKS(6)) dut6 (
    .clk(clk), .rst(rst), .alloc_req_i(areq), .alloc_gnt_o(gnt[1]), .alloc_block_idx_o(aidx[1]),
    .free_req_i(freq), .free_block_idx_i(fidx), .free_count_o(cnt[1]), .init_done_o(done[1]),
    .err_double_free_o(edb[1]), .err_bad_idx_o(ebad[1]));
  function automatic int nb(input int k);
    return k == 0 ? 8 : 6;
  endfunction
  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[nb=%0d] @%0t: got %0h want %0h", nm, nb(k), $time, act, exp);
    end
  endtask
  task automatic expect_push(input int k);
    st_t s;
    int n = mq[k].size();
    s.chk = !rst;
    s.gnt = run[k] && areq && n > 0;
    s.idx = run[k] && n > 0 ? 3'(mq[k][0]) : 3'd0;
    s.cnt = n;
    s.done = run[k];
    s.db = mdb[k];
    s.bad = mbad[k];
    sq[k].push_back(s);
    if (s.gnt) gq[k].push_back(mq[k][0]);
  endtask
  task automatic model_step(input int k);
    int n = nb(k);
    bit g;
    int h;
    if (rst) begin
      mq[k].delete();
      for (int i = 0; i < 8; i++) inuse[k][i] = 0;
      icnt[k] = 0; run[k] = 0; mdb[k] = 0; mbad[k] = 0;
      return;
    end
    if (!run[k]) begin
      mq[k].push_back(icnt[k]);
      icnt[k]++;
      if (icnt[k] == n) run[k] = 1;
      return;
    end
    g = areq && mq[k].size() > 0;
    h = g ? mq[k][0] : -1;
    if (freq) begin
      if (int'(fidx) >= n) mbad[k] = 1;
      else if (!inuse[k][fidx]) mdb[k] = 1;
      else begin
        inuse[k][fidx] = 0;
        mq[k].push_back(int'(fidx));
      end
    end
    if (g) begin
      void'(mq[k].pop_front());
      inuse[k][h] = 1;
    end
  endtask
  task automatic cyc(input bit r, input bit a, input bit f, input logic [2:0] fi);
    rst = r; areq = a && !r; freq = f; fidx = fi;
    for (int k = 0; k < 2; k++) begin
      expect_push(k);
      model_step(k);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic rnd(input int cycles);
    int c[$];
    logic [2:0] fi;
    repeat (cycles) begin
      c.delete();
      for (int i = 0; i < 6; i++) if (inuse[1][i]) c.push_back(i);
      fi = (c.size() > 0 && $urandom_range(0, 4) != 0) ? 3'(c[$urandom_range(0, c.size() - 1)]) : 3'($urandom_range(0, 7));
      cyc(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), fi);
    end
  endtask
  always @(negedge clk) begin
    st_t s;
    for (int k = 0; k < 2; k++) begin
      if (sq[k].size() != 0) begin
        s = sq[k].pop_front();
        if (s.chk) begin
          chk("gnt", k, 32'(gnt[k]), 32'(s.gnt));
          chk("idx", k, 32'(aidx[k]), 32'(s.idx));
          chk("count", k, 32'(cnt[k]), 32'(s.cnt));
          chk("init_done", k, 32'(done[k]), 32'(s.done));
          chk("err_double", k, 32'(edb[k]), 32'(s.db));
          chk("err_bad", k, 32'(ebad[k]), 32'(s.bad));
        end
      end
      if (gnt[k] === 1'b1) begin
        if (gq[k].size() == 0) begin
          total++;
          bad++;
          $display("FAIL grant_unexpected[nb=%0d] @%0t: got idx %0h want no grant", nb(k), $time, aidx[k]);
        end else chk("grant_idx", k, 32'(aidx[k]), 32'(gq[k].pop_front()));
      end
    end
  end
  initial begin
    rst = 1; areq = 0; freq = 0; fidx = 0;
    @(posedge clk);
    #1;
    cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
    repeat (8) cyc(0, 1, 1, 3'($urandom_range(0, 7)));
    repeat (9) cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 5); cyc(0, 0, 1, 2); cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 3); cyc(0, 0, 1, 3); cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 7);
    repeat (3) cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 4); cyc(0, 1, 0, 0);
    rnd(300);
    cyc(1, 0, 0, 0);
    repeat (8) cyc(0, 1, 1, 3'($urandom_range(0, 7)));
    rnd(200);
    cyc(0, 0, 0, 0);
    @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("grants_outstanding", k, 32'(gq[k].size()), 32'd0);
      chk("status_outstanding", k, 32'(sq[k].size()), 32'd0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/free_list.md
Name: free_list

Overview:
- Shared block-index allocator for the packet buffer memory.
- Sits directly downstream of the port arbiter's free-list channels:
  - serves serialized allocation requests (one per cycle) with a same-cycle grant and block index;
  - accepts serialized block-free returns from the read side.
- Internally a circular FIFO of free indices plus an in-use bitmap for free-error detection.
- Initializes itself after reset by loading every index.

Parameters:
- ADDR_W, 8, width of a block index.
- NUM_BLOCKS, 256, number of buffer blocks; 2 <= NUM_BLOCKS <= 2**ADDR_W.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- alloc_req_i  input  1  request one free block this cycle.
- alloc_gnt_o  output  1  grant; combinational, same cycle as the request.
- alloc_block_idx_o  output  ADDR_W  granted block index; valid when alloc_gnt_o=1.
- free_req_i  input  1  return one block this cycle.
- free_block_idx_i  input  ADDR_W  index being returned.
- free_count_o  output  ADDR_W+1  number of free blocks (registered).
- init_done_o  output  1  high once initialization has completed (registered).
- err_double_free_o  output  1  sticky: a free hit a block not marked in-use.
- err_bad_idx_o  output  1  sticky: a free used an index >= NUM_BLOCKS.

Behaviour:
- Interface: one clock (clk); synchronous active-high reset (rst).
- Reset:
  - state=INIT; wr_ptr=rd_ptr=0; init counter=0; free_count_o=0; bitmap all 0.
  - init_done_o=0; both error flags=0; alloc_gnt_o=0.
- Storage: NUM_BLOCKS x ADDR_W array with combinational read at rd_ptr.
- Pointers wrap from NUM_BLOCKS-1 to 0; NUM_BLOCKS need not be a power of 2.
- INIT state:
  - each cycle writes init counter to fifo[counter], increments counter and free_count_o;
  - after writing NUM_BLOCKS-1, next state=RUN, wr_ptr=0 (wrapped), init_done_o=1;
  - INIT lasts exactly NUM_BLOCKS cycles after rst deasserts;
  - alloc_gnt_o=0 throughout INIT;
  - free_req_i during INIT is ignored and does not set any error flag; upstream must not free before init_done_o.
- RUN state, allocation:
  - alloc_gnt_o = alloc_req_i && (free_count_o != 0);
  - alloc_block_idx_o = fifo[rd_ptr] whenever free_count_o != 0, else 0;
  - on a granted edge: rd_ptr++, bitmap[idx]=1;
  - a back-to-back request next cycle sees the new head, so one grant per cycle is sustained.
- RUN state, free (valid):
  - condition: free_block_idx_i < NUM_BLOCKS and bitmap[idx]=1;
  - fifo[wr_ptr]=idx, wr_ptr++, bitmap[idx]=0.
- RUN state, free (invalid):
  - idx >= NUM_BLOCKS: no state change, err_bad_idx_o=1;
  - bitmap[idx]=0: no state change, err_double_free_o=1.
- Count update: free_count_o += valid_free - gnt; saturation is impossible by construction.
- Simultaneous alloc grant and valid free:
  - both take effect; free_count_o unchanged.
  - If the free index equals the index being granted that same cycle, the grant wins and the bitmap bit is set; that bit was 0 at the edge, so the free is flagged as a double-free and dropped.
- Empty (free_count_o=0) with alloc_req_i and a free in the same cycle:
  - no bypass; alloc_gnt_o=0;
  - the freed block becomes grantable on the next cycle.
- Full (free_count_o=NUM_BLOCKS): every bitmap bit is 0, so any free is a double-free.
- Error flags clear only on rst.
- Reset mid-operation discards all state and re-enters INIT.

Test Plan:
- NUM_BLOCKS=8, ADDR_W=3; release rst -> init_done_o rises exactly 8 cycles later; free_count_o=8; alloc_gnt_o=0 throughout INIT even with alloc_req_i=1.
- 8 back-to-back alloc requests after init -> grants every cycle with idx 0,1,...,7; free_count_o=0; 9th request -> alloc_gnt_o=0, idx output 0.
- Free 5, 2 then alloc twice -> grants idx 5 then 2 (FIFO order); free_count_o 0->1->2->1->0.
- Free idx 3 twice after allocating it once -> first accepted, second sets err_double_free_o=1; count unchanged by the second; flag stays 1 until rst.
- NUM_BLOCKS=6, ADDR_W=3: free idx 7 -> err_bad_idx_o=1, no count change. Cycle through 12 alloc/free pairs -> pointers wrap 5->0 correctly, indices returned in freed order.
- Empty list, same cycle alloc_req_i=1 and free idx 4 -> alloc_gnt_o=0; next cycle request -> grant idx 4. Assert rst mid-traffic -> count 0, flags clear, INIT repeats for 8 cycles.
